// File: rtl/odometer_scan_pkg.sv
// Shared definitions for the odometer test-chip scan host: command opcodes,
// FSM state encoding and the command data width.
package odometer_scan_pkg;

  localparam int CMD_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_MEASURE    = 2'b01,
    OP_READ       = 2'b10,
    OP_CHIP_RESET = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    LOAD_P    = 3'd2,
    MEAS      = 3'd3,
    SHIFT_OUT = 3'd4,
    RSP       = 3'd5,
    CHIPRST   = 3'd6
  } state_e;

endpackage

// File: rtl/odometer_scan_host_if.sv
// Command / response handshake between the host register bank (master) and
// the odometer scan host (slave).
interface odometer_scan_host_if
  import odometer_scan_pkg::*;
#(
  parameter int DOUT_W = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  op_e                   cmd_op;
  logic [CMD_DATA_W-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DOUT_W-1:0]     rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/odometer_scan_phase.sv
// Scan bit-period divider. A period is DIV low cycles followed by DIV high
// cycles. o_sample marks the last low cycle (the scan clock rises after it),
// o_period_end marks the last high cycle (the next bit starts after it).
module odometer_scan_phase #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_clear,
  output logic o_sample,
  output logic o_period_end
);

  localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic             r_run;
  logic             r_high;
  logic [CNT_W-1:0] r_cnt;

  // Phase counter: runs from start until cleared, toggling phase every DIV cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_run  <= 1'b0;
      r_high <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_high <= 1'b0;
      r_cnt  <= '0;
    end else if (r_run) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_high <= ~r_high;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sample     = r_run && !r_high && (r_cnt == LAST);
  assign o_period_end = r_run &&  r_high && (r_cnt == LAST);

endmodule

// File: rtl/odometer_scan_host.sv
// Odometer test-chip scan host: turns WRITE / MEASURE / READ / CHIP_RESET
// commands into phased scan clocks, LOAD, MEAS_TRIG and RESETB pin activity.
// Every pin and handshake output comes straight from a flop.
// Optional build macro: SCANIN_CHECK_EN enables the scan-in loopback check
// (shadow of the last written word compared with the chain tail, sticky CHK_ERR).
module odometer_scan_host
  import odometer_scan_pkg::*;
#(
  parameter int CFG_W  = 8,
  parameter int DOUT_W = 32,
  parameter int DIV    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  odometer_scan_host_if.slave  bus,
  output logic                 o_busy,
  output logic                 o_chk_err,
  output logic                 o_scanin_din,
  output logic                 o_scanin_clk,
  output logic                 o_load,
  output logic                 o_meas_trig,
  output logic                 o_scanout_clk,
  output logic                 o_resetb,
  input  logic                 i_scanout_dout,
  input  logic                 i_scanin_dout
);

  localparam int MAX_W = (CFG_W > DOUT_W) ? CFG_W : DOUT_W;
  localparam int BIT_W = $clog2(MAX_W + 1);

  state_e                r_state, w_state_nxt;
  logic                  r_cmd_ready, r_busy, r_rsp_valid;
  logic [DOUT_W-1:0]     r_rsp_data, w_rsp_data_nxt;
  logic                  r_din, r_sin_clk, r_sout_clk, r_load, r_trig, r_resetb;
  logic                  w_din_nxt, w_sin_clk_nxt, w_sout_clk_nxt, w_load_nxt, w_trig_nxt, w_resetb_nxt;
  logic                  w_rsp_valid_nxt;
  logic [CMD_DATA_W-1:0] r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [CFG_W-1:0]      r_cfg, w_cfg_nxt, w_cfg_shift;
  logic [DOUT_W-1:0]     r_dout_sreg, w_dout_nxt;
  logic                  w_accept, w_sample, w_period_end, w_last_in, w_last_out;
  logic                  w_phase_start, w_phase_clear;

  assign w_accept    = (r_state == IDLE) && bus.cmd_valid;
  assign w_last_in   = (r_bit == BIT_W'(CFG_W - 1));
  assign w_last_out  = (r_bit == BIT_W'(DOUT_W - 1));
  assign w_cfg_shift = r_cfg << 1;

  odometer_scan_phase #(.DIV(DIV)) u_phase (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_phase_start),
    .i_clear      (w_phase_clear),
    .o_sample     (w_sample),
    .o_period_end (w_period_end)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode from the current state, accepted command and phase strobes.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_WRITE:   w_state_nxt = SHIFT_IN;
            OP_MEASURE: w_state_nxt = MEAS;
            OP_READ:    w_state_nxt = SHIFT_OUT;
            default:    w_state_nxt = CHIPRST;
          endcase
        end
      end
      SHIFT_IN:  if (w_period_end && w_last_in)  w_state_nxt = LOAD_P;
      LOAD_P:    if (r_cnt == '0)                w_state_nxt = IDLE;
      MEAS:      if (r_cnt <= CMD_DATA_W'(1))    w_state_nxt = IDLE;
      SHIFT_OUT: if (w_period_end && w_last_out) w_state_nxt = RSP;
      RSP:       if (bus.rsp_ready)              w_state_nxt = IDLE;
      CHIPRST:   if (r_cnt <= CMD_DATA_W'(1))    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; pins change on the same edge as the state.
  always_comb begin
    w_din_nxt       = r_din;
    w_sin_clk_nxt   = r_sin_clk;
    w_sout_clk_nxt  = r_sout_clk;
    w_load_nxt      = r_load;
    w_trig_nxt      = r_trig;
    w_resetb_nxt    = r_resetb;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_cfg_nxt       = r_cfg;
    w_dout_nxt      = r_dout_sreg;
    w_phase_start   = 1'b0;
    w_phase_clear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_bit_nxt = '0;
          case (bus.cmd_op)
            OP_WRITE: begin
              w_cfg_nxt     = bus.cmd_data[CFG_W-1:0];
              w_din_nxt     = bus.cmd_data[CFG_W-1];
              w_phase_start = 1'b1;
            end
            OP_MEASURE: begin
              w_cnt_nxt  = bus.cmd_data;
              w_trig_nxt = (bus.cmd_data != '0);
            end
            OP_READ: begin
              w_dout_nxt    = '0;
              w_phase_start = 1'b1;
            end
            default: begin
              w_cnt_nxt    = CMD_DATA_W'(2 * DIV);
              w_resetb_nxt = 1'b0;
            end
          endcase
        end
      end
      SHIFT_IN: begin
        if (w_sample) w_sin_clk_nxt = 1'b1;
        if (w_period_end) begin
          w_sin_clk_nxt = 1'b0;
          if (w_last_in) begin
            w_phase_clear = 1'b1;
            w_din_nxt     = 1'b0;
            w_load_nxt    = 1'b1;
            w_cnt_nxt     = CMD_DATA_W'(DIV);
          end else begin
            w_cfg_nxt = w_cfg_shift;
            w_din_nxt = w_cfg_shift[CFG_W-1];
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      LOAD_P: begin
        // LOAD spans DIV cycles; one more cycle then returns to IDLE.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CMD_DATA_W'(1)) w_load_nxt = 1'b0;
        end
      end
      MEAS: begin
        if (r_cnt > CMD_DATA_W'(1)) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_cnt_nxt  = '0;
          w_trig_nxt = 1'b0;
        end
      end
      SHIFT_OUT: begin
        if (w_sample) begin
          w_sout_clk_nxt = 1'b1;
          w_dout_nxt     = DOUT_W'({r_dout_sreg, i_scanout_dout});
        end
        if (w_period_end) begin
          w_sout_clk_nxt = 1'b0;
          if (w_last_out) begin
            w_phase_clear   = 1'b1;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = r_dout_sreg;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      RSP: begin
        if (bus.rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      CHIPRST: begin
        if (r_cnt > CMD_DATA_W'(1)) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_cnt_nxt    = '0;
          w_resetb_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset puts every pin at its idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_din       <= 1'b0;
      r_sin_clk   <= 1'b0;
      r_sout_clk  <= 1'b0;
      r_load      <= 1'b0;
      r_trig      <= 1'b0;
      r_resetb    <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_cfg       <= '0;
      r_dout_sreg <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_din       <= w_din_nxt;
      r_sin_clk   <= w_sin_clk_nxt;
      r_sout_clk  <= w_sout_clk_nxt;
      r_load      <= w_load_nxt;
      r_trig      <= w_trig_nxt;
      r_resetb    <= w_resetb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_cfg       <= w_cfg_nxt;
      r_dout_sreg <= w_dout_nxt;
    end
  end

`ifdef SCANIN_CHECK_EN
  logic [CFG_W-1:0] r_shadow, r_word, r_echo;
  logic             r_chk_err;

  // Compare the chain tail against the previously loaded word; mismatches are sticky.
  // NOTE: the shadow is explicitly reset because its contents are compared
  // on the very first WRITE; an unreset shadow would flag random errors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_word    <= '0;
      r_echo    <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_accept && bus.cmd_op == OP_WRITE) begin
        r_word <= bus.cmd_data[CFG_W-1:0];
        r_echo <= r_shadow;
      end
      if (r_state == SHIFT_IN && w_sample) begin
        if (i_scanin_dout != r_echo[CFG_W-1]) r_chk_err <= 1'b1;
        r_echo <= r_echo << 1;
      end
      if (r_state == SHIFT_IN && w_state_nxt == LOAD_P) r_shadow <= r_word;
    end
  end

  assign o_chk_err = r_chk_err;
`else
  logic w_unused_scanin_dout;
  assign w_unused_scanin_dout = i_scanin_dout;
  assign o_chk_err            = 1'b0;
`endif

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign o_busy        = r_busy;
  assign o_scanin_din  = r_din;
  assign o_scanin_clk  = r_sin_clk;
  assign o_scanout_clk = r_sout_clk;
  assign o_load        = r_load;
  assign o_meas_trig   = r_trig;
  assign o_resetb      = r_resetb;

endmodule

// File: tb/tb_odometer_scan_host.sv
// Directed bench for odometer_scan_host (CFG_W=8, DOUT_W=32, DIV=2).
// Chip scan-in chain and scan-out chain are modelled inline in the command
// runner so everything happens in one process.
module tb_odometer_scan_host;
  import odometer_scan_pkg::*;

  localparam int CFG_W  = 8;
  localparam int DOUT_W = 32;
  localparam int DIV    = 2;
`ifdef SCANIN_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic o_busy, o_chk_err, o_scanin_din, o_scanin_clk, o_load, o_meas_trig;
  logic o_scanout_clk, o_resetb;
  logic tb_scanout_dout = 1'b0;
  logic tb_scanin_dout  = 1'b0;

  odometer_scan_host_if #(.DOUT_W(DOUT_W)) bus ();

  odometer_scan_host #(.CFG_W(CFG_W), .DOUT_W(DOUT_W), .DIV(DIV)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .bus            (bus),
    .o_busy         (o_busy),
    .o_chk_err      (o_chk_err),
    .o_scanin_din   (o_scanin_din),
    .o_scanin_clk   (o_scanin_clk),
    .o_load         (o_load),
    .o_meas_trig    (o_meas_trig),
    .o_scanout_clk  (o_scanout_clk),
    .o_resetb       (o_resetb),
    .i_scanout_dout (tb_scanout_dout),
    .i_scanin_dout  (tb_scanin_dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // results of the last run_cmd
  int          n_cyc, in_rises, out_rises, load_cyc, trig_cyc, rstb_low, first_rise;
  logic [15:0] in_word;
  logic        first_din, first_busy;
  // chip models
  logic [CFG_W-1:0] chain = '0;
  logic [31:0]      chip_sr = '0;
  int               corrupt_bit = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chain = '0;
    corrupt_bit = -1;
    tb_scanin_dout = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Issue one command and follow it cycle by cycle until CMD_READY or RSP_VALID.
  task automatic run_cmd(input op_e op, input logic [15:0] data, input int limit);
    logic prev_in, prev_out;
    tb_scanin_dout  = chain[CFG_W-1] ^ (corrupt_bit == 0);
    tb_scanout_dout = chip_sr[31];
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    n_cyc = 0; in_rises = 0; out_rises = 0; load_cyc = 0; trig_cyc = 0;
    rstb_low = 0; first_rise = -1; in_word = '0;
    first_din  = o_scanin_din;
    first_busy = o_busy;
    prev_in  = 1'b0;
    prev_out = 1'b0;
    while (!bus.cmd_ready && !bus.rsp_valid && n_cyc < limit) begin
      if (o_load)      load_cyc++;
      if (o_meas_trig) trig_cyc++;
      if (!o_resetb)   rstb_low++;
      if (o_scanin_clk && !prev_in) begin
        if (first_rise < 0) first_rise = n_cyc;
        in_word = {in_word[14:0], o_scanin_din};
        chain   = {chain[CFG_W-2:0], o_scanin_din};
        in_rises++;
        tb_scanin_dout = chain[CFG_W-1] ^ (in_rises == corrupt_bit);
      end
      if (o_scanout_clk && !prev_out) begin
        out_rises++;
        chip_sr = chip_sr << 1;
        tb_scanout_dout = chip_sr[31];
      end
      prev_in  = o_scanin_clk;
      prev_out = o_scanout_clk;
      step();
      n_cyc++;
    end
    check("cmd_bound", 32'(n_cyc < limit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hold_bad;
    logic [31:0] held;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    do_reset();
    check("rst_ready",  32'(bus.cmd_ready), 32'd1);
    check("rst_rspv",   32'(bus.rsp_valid), 32'd0);
    check("rst_rspd",   bus.rsp_data, 32'h0);
    check("rst_busy",   32'(o_busy), 32'd0);
    check("rst_chkerr", 32'(o_chk_err), 32'd0);
    check("rst_pins", 32'({o_scanin_din, o_scanin_clk, o_scanout_clk, o_load, o_meas_trig, o_resetb}), 32'b000001);

    // WRITE 0xA5: 8 bit periods of 4 cycles, LOAD 2 cycles, ready after 35
    run_cmd(OP_WRITE, 16'h00A5, 200);
    check("wr_first_din", 32'(first_din), 32'd1);
    check("wr_busy",      32'(first_busy), 32'd1);
    check("wr_first_rise", 32'(first_rise), 32'(DIV));
    check("wr_rises",  32'(in_rises), 32'd8);
    check("wr_word",   32'(in_word), 32'h00A5);
    check("wr_load",   32'(load_cyc), 32'd2);
    check("wr_cycles", 32'(n_cyc), 32'd35);
    check("wr_other",  32'(out_rises + trig_cyc + rstb_low), 32'd0);
    check("wr_idle_busy", 32'(o_busy), 32'd0);
    check("wr_chkerr", 32'(o_chk_err), 32'd0);

    // READ 0xDEADBEEF with the response held off for 10 cycles
    chip_sr = 32'hDEADBEEF;
    run_cmd(OP_READ, 16'h0000, 400);
    check("rd_cycles", 32'(n_cyc), 32'd128);
    check("rd_rises",  32'(out_rises), 32'd32);
    check("rd_in_quiet", 32'(in_rises), 32'd0);
    check("rd_valid",  32'(bus.rsp_valid), 32'd1);
    check("rd_data",   bus.rsp_data, 32'hDEADBEEF);
    held = bus.rsp_data;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.rsp_valid || bus.rsp_data !== held || bus.cmd_ready) hold_bad++;
    end
    check("rd_hold", 32'(hold_bad), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rd_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd_ready", 32'(bus.cmd_ready), 32'd1);

    // MEASURE 100 and MEASURE 0
    run_cmd(OP_MEASURE, 16'd100, 300);
    check("ms100_trig",   32'(trig_cyc), 32'd100);
    check("ms100_cycles", 32'(n_cyc), 32'd100);
    run_cmd(OP_MEASURE, 16'd0, 50);
    check("ms0_trig",   32'(trig_cyc), 32'd0);
    check("ms0_cycles", 32'(n_cyc), 32'd1);

    // CHIP_RESET: RESETB low 2*DIV cycles, no scan clocks
    run_cmd(OP_CHIP_RESET, 16'h0000, 50);
    check("cr_low",    32'(rstb_low), 32'(2 * DIV));
    check("cr_cycles", 32'(n_cyc), 32'(2 * DIV));
    check("cr_clocks", 32'(in_rises + out_rises), 32'd0);
    check("cr_resetb", 32'(o_resetb), 32'd1);

    // RESET in the middle of SHIFT_OUT
    chip_sr = 32'hDEADBEEF;
    tb_scanout_dout = chip_sr[31];
    bus.cmd_op    = OP_READ;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    repeat (20) step();
    check("mid_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    step();
    check("mid_pins", 32'({o_scanin_din, o_scanin_clk, o_scanout_clk, o_load, o_meas_trig, o_resetb}), 32'b000001);
    check("mid_rspv",  32'(bus.rsp_valid), 32'd0);
    check("mid_rspd",  bus.rsp_data, 32'h0);
    check("mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_busy0", 32'(o_busy), 32'd0);
    rst = 1'b0;
    chain = '0;
    step();
    run_cmd(OP_WRITE, 16'h005A, 200);
    check("post_first_din", 32'(first_din), 32'd0);
    check("post_word",   32'(in_word), 32'h005A);
    check("post_cycles", 32'(n_cyc), 32'd35);
    check("post_load",   32'(load_cyc), 32'd2);

    // loopback: clean pair of writes
    do_reset();
    run_cmd(OP_WRITE, 16'h003C, 200);
    run_cmd(OP_WRITE, 16'h0081, 200);
    check("lb_clean", 32'(o_chk_err), 32'd0);

    // loopback: one echoed bit corrupted on the second write
    do_reset();
    run_cmd(OP_WRITE, 16'h003C, 200);
    corrupt_bit = 5;
    run_cmd(OP_WRITE, 16'h0081, 200);
    corrupt_bit = -1;
    check("lb_corrupt", 32'(o_chk_err), 32'(CHECK_ON));
    run_cmd(OP_MEASURE, 16'd3, 50);
    check("lb_sticky", 32'(o_chk_err), 32'(CHECK_ON));
    do_reset();
    check("lb_cleared", 32'(o_chk_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
